intersection_scheduler: RTL and testbench
=========================================

// Module: intersection_scheduler
// PURPOSE
//  Two-approach intersection controller: sequences main road A and side road B through
//  green/yellow/all-red phases. Arbitrates green between vehicle sense, latched pedestrian
//  requests and emergency preemption. Drives {RED,YELLOW,GREEN} lamp groups and walk signals
//  for each approach. A is the rest direction.
// PARAMETERS
//  MIN_GREEN    10  minimum green duration, cycles (must be >= WALK_TIME)
//  MAX_GREEN    30  maximum B green duration while B demand persists, cycles
//  YELLOW_TIME   4  yellow duration, cycles
//  ALL_RED_TIME  2  all-red clearance duration, cycles
//  WALK_TIME     8  walk assertion length at start of a served green, cycles
//  TW            8  timer width; every duration parameter is <= 2**TW-1
// PORTS
//  clk        in   1  clock
//  reset      in   1  asynchronous, active-high reset
//  veh_b      in   1  level: vehicle waiting/present on B
//  ped_req_a  in   1  1-cycle pulse: pedestrian request, crossing with A green
//  ped_req_b  in   1  1-cycle pulse: pedestrian request, crossing with B green
//  emg_req    in   1  level: emergency preemption request
//  emg_dir    in   1  preempt target direction: 0 = A, 1 = B (sampled while emg_req=1)
//  light_a    out  3  A lamps {R,Y,G}, one-hot
//  light_b    out  3  B lamps {R,Y,G}, one-hot
//  walk_a     out  1  walk indication, A crossing
//  walk_b     out  1  walk indication, B crossing
//  phase      out  3  state code: 0 A_GRN, 1 A_YEL, 2 RED_AB, 3 B_GRN, 4 B_YEL, 5 RED_BA
//  emg_active out  1  high while the current green is held by preemption
// BEHAVIOUR
//  - Reset (async): phase=A_GRN, timer=0, light_a=001, light_b=100, walk_*=0, emg_active=0,
//    ped pendings cleared. All outputs registered; they change on the edge that changes phase.
//  - timer resets to 0 on every phase entry, increments each cycle, saturates at 2**TW-1.
//  - Fixed phases: A_YEL/B_YEL last exactly YELLOW_TIME cycles (exit at timer==YELLOW_TIME-1).
//    RED_AB/RED_BA last exactly ALL_RED_TIME cycles. Lamps: the yellowing side shows 010,
//    the other 100. In both all-red phases both sides show 100.
//  - Pending flags ped_pend_x: set by ped_req_x, cleared on the edge entering X green.
//    demand_b = veh_b | ped_pend_b.
//  - A_GRN (A=001, B=100): exit to A_YEL when timer>=MIN_GREEN-1 && demand_b. Otherwise rest
//    indefinitely. A ped_req_a during A_GRN stays pending until the next A_GRN entry.
//  - B_GRN (A=100, B=001): exit to B_YEL when timer==MAX_GREEN-1, or when timer>=MIN_GREEN-1
//    && (!veh_b | ped_pend_a).
//  - RED_AB -> B_GRN and RED_BA -> A_GRN. Exception: if emg_req=1 at exit, the next green is
//    emg_dir. RED_AB->A_GRN and RED_BA->B_GRN are legal only then.
//  - Walk: on entry to X green, walk_x=1 for exactly WALK_TIME cycles if ped_pend_x was set,
//    or if ped_req_x is high on the entry edge (that request counts as served).
//  - Preemption: while emg_req=1 and the current green is not emg_dir, the green exits to
//    yellow on the next edge regardless of timer. walk_* drop on that same edge.
//  - Preemption: yellow/all-red in progress always complete their full duration (no skipping).
//  - Preemption: while emg_req=1 and the current green is emg_dir, emg_active=1, the green
//    holds (no exit), and walk_* are forced 0. Pendings are retained.
//  - On emg_req falling while held: emg_active=0 and timer reloads 0. Normal exit rules
//    resume, so a full MIN_GREEN is guaranteed.
//  - Safety invariant: never light_a[0] && light_b[0]. Every green->green change passes
//    yellow then all-red.
//  - Reset mid-phase: immediate return to the reset state. No clearance phases are inserted.
// TESTING
//  Reset released, all inputs 0 for 200 cycles -> phase=0, light_a=001, light_b=100 throughout.
//  veh_b=1 held from cycle 3 -> A_YEL cycles 10-13, RED_AB 14-15, B_GRN 16-45, B_YEL at 46.
//  ped_req_b pulse at cycle 2, veh_b=0 -> B_GRN at 16, walk_b=1 cycles 16-23, B_YEL at 26.
//  Preempt in B_GRN at timer=2 (emg_req=1, emg_dir=0) -> B_YEL next edge for 4 cycles.
//    Then RED_BA for 2 cycles, then A_GRN with emg_active=1 until emg_req=0.
//  In A_GRN rest, emg_req=1 & emg_dir=1 with veh_b=0 -> A_YEL next edge, B_GRN held while
//    emg_req=1; drop emg_req -> B_GRN lasts 10 more cycles.
//  reset pulsed during B_YEL -> light_a=001, light_b=100, phase=0 without waiting for a clock.
//    ped_pend cleared; assertion: no cycle with both greens lit across all scenarios.

Source files
------------

// File: rtl/intersection_scheduler.sv
// Two-approach intersection controller: A rests green, B is served on demand, with
// latched pedestrian requests, emergency preemption and registered lamp/walk outputs.
module intersection_scheduler #(
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 30,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 8,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       veh_b,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase,
  output logic       emg_active
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5
  } phase_e;

  localparam logic [2:0]    LAMP_R    = 3'b100;
  localparam logic [2:0]    LAMP_Y    = 3'b010;
  localparam logic [2:0]    LAMP_G    = 3'b001;
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] MIN_LAST  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] RED_LAST  = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] WALK_LAST = TW'(WALK_TIME - 1);

  phase_e        phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pend_a_q, ped_pend_a_d;
  logic          ped_pend_b_q, ped_pend_b_d;
  logic          walk_a_q, walk_a_d;
  logic          walk_b_q, walk_b_d;
  logic          emg_active_q, emg_active_d;
  logic [2:0]    light_a_q, light_a_d;
  logic [2:0]    light_b_q, light_b_d;
  logic          green_dir;
  logic          demand_b;
  logic          serve_a;
  logic          serve_b;

  assign demand_b  = veh_b | ped_pend_b_q;
  assign green_dir = (phase_q == B_GRN);

  always_comb begin
    phase_d      = phase_q;
    timer_d      = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    emg_active_d = 1'b0;
    serve_a      = 1'b0;
    serve_b      = 1'b0;
    walk_a_d     = 1'b0;
    walk_b_d     = 1'b0;
    ped_pend_a_d = ped_pend_a_q | ped_req_a;
    ped_pend_b_d = ped_pend_b_q | ped_req_b;
    light_a_d    = LAMP_R;
    light_b_d    = LAMP_R;

    case (phase_q)
      A_GRN, B_GRN: begin
        if (emg_req && (emg_dir == green_dir)) begin
          emg_active_d = 1'b1;
        end else if (emg_req) begin
          phase_d = green_dir ? B_YEL : A_YEL;
        end else if (emg_active_q) begin
          // Hold released: restart the green as if freshly entered so MIN_GREEN and walk are honoured.
          timer_d = '0;
          serve_a = !green_dir;
          serve_b = green_dir;
        end else if (!green_dir && (timer_q >= MIN_LAST) && demand_b) begin
          phase_d = A_YEL;
        end else if (green_dir && ((timer_q == MAX_LAST) ||
                     ((timer_q >= MIN_LAST) && (!veh_b || ped_pend_a_q)))) begin
          phase_d = B_YEL;
        end else begin
          walk_a_d = walk_a_q && (timer_q < WALK_LAST);
          walk_b_d = walk_b_q && (timer_q < WALK_LAST);
        end
      end
      A_YEL:   if (timer_q == YEL_LAST) phase_d = RED_AB;
      B_YEL:   if (timer_q == YEL_LAST) phase_d = RED_BA;
      RED_AB:  if (timer_q == RED_LAST) phase_d = (emg_req && !emg_dir) ? A_GRN : B_GRN;
      RED_BA:  if (timer_q == RED_LAST) phase_d = (emg_req && emg_dir) ? B_GRN : A_GRN;
      default: phase_d = A_GRN;
    endcase

    if (phase_d != phase_q) begin
      timer_d = '0;
      if ((phase_d == A_GRN) || (phase_d == B_GRN)) begin
        if (emg_req && (emg_dir == (phase_d == B_GRN))) begin
          emg_active_d = 1'b1;
        end else begin
          serve_a = (phase_d == A_GRN);
          serve_b = (phase_d == B_GRN);
        end
      end
    end

    if (serve_a) begin
      walk_a_d     = ped_pend_a_q | ped_req_a;
      ped_pend_a_d = 1'b0;
    end
    if (serve_b) begin
      walk_b_d     = ped_pend_b_q | ped_req_b;
      ped_pend_b_d = 1'b0;
    end

    // Lamps follow the next phase so they change on the same edge as the phase code.
    case (phase_d)
      A_GRN:   light_a_d = LAMP_G;
      A_YEL:   light_a_d = LAMP_Y;
      B_GRN:   light_b_d = LAMP_G;
      B_YEL:   light_b_d = LAMP_Y;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= A_GRN;
      timer_q      <= '0;
      ped_pend_a_q <= 1'b0;
      ped_pend_b_q <= 1'b0;
      walk_a_q     <= 1'b0;
      walk_b_q     <= 1'b0;
      emg_active_q <= 1'b0;
      light_a_q    <= LAMP_G;
      light_b_q    <= LAMP_R;
    end else begin
      phase_q      <= phase_d;
      timer_q      <= timer_d;
      ped_pend_a_q <= ped_pend_a_d;
      ped_pend_b_q <= ped_pend_b_d;
      walk_a_q     <= walk_a_d;
      walk_b_q     <= walk_b_d;
      emg_active_q <= emg_active_d;
      light_a_q    <= light_a_d;
      light_b_q    <= light_b_d;
    end
  end

  assign phase      = phase_q;
  assign light_a    = light_a_q;
  assign light_b    = light_b_q;
  assign walk_a     = walk_a_q;
  assign walk_b     = walk_b_q;
  assign emg_active = emg_active_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: cycle-by-cycle phase/lamp/walk/preempt
// expectations for each scenario, plus a continuous no-double-green monitor.
module tb_intersection_scheduler;

  logic       clk;
  logic       reset;
  logic       veh_b;
  logic       ped_req_a;
  logic       ped_req_b;
  logic       emg_req;
  logic       emg_dir;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic       walk_a;
  logic       walk_b;
  logic [2:0] phase;
  logic       emg_active;

  int tests = 0;
  int fails = 0;

  intersection_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .veh_b      (veh_b),
    .ped_req_a  (ped_req_a),
    .ped_req_b  (ped_req_b),
    .emg_req    (emg_req),
    .emg_dir    (emg_dir),
    .light_a    (light_a),
    .light_b    (light_b),
    .walk_a     (walk_a),
    .walk_b     (walk_b),
    .phase      (phase),
    .emg_active (emg_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word {phase, light_a, light_b, walk_a, walk_b, emg_active}.
  function automatic logic [11:0] expv(input int ph, input logic wa, input logic wb, input logic ea);
    logic [2:0] la;
    logic [2:0] lb;
    case (ph)
      0:       begin la = 3'b001; lb = 3'b100; end
      1:       begin la = 3'b010; lb = 3'b100; end
      3:       begin la = 3'b100; lb = 3'b001; end
      4:       begin la = 3'b100; lb = 3'b010; end
      default: begin la = 3'b100; lb = 3'b100; end
    endcase
    return {3'(ph), la, lb, wa, wb, ea};
  endfunction

  task automatic chk(input string tag, input int c, input int ph,
                     input logic wa, input logic wb, input logic ea);
    logic [11:0] obs;
    logic [11:0] exp;
    obs = {phase, light_a, light_b, walk_a, walk_b, emg_active};
    exp = expv(ph, wa, wb, ea);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s c%0d: observed {ph,la,lb,wa,wb,ea}=%03h expected %03h", tag, c, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    veh_b = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0; emg_req = 1'b0; emg_dir = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    tests++;
    assert (!(light_a[0] && light_b[0])) else begin
      fails++;
      $error("FAIL both_green: light_a=%b light_b=%b expected not both green", light_a, light_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int ph;
    reset = 1'b1;
    veh_b = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0; emg_req = 1'b0; emg_dir = 1'b0;

    // Idle: A rests green indefinitely
    do_reset();
    for (int c = 0; c < 200; c++) begin
      chk("idle", c, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    $display("[TB] scenario idle done");

    // Vehicle on B from cycle 3: B holds to MAX_GREEN
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      ph = (c < 10) ? 0 : (c < 14) ? 1 : (c < 16) ? 2 : (c < 46) ? 3 : (c < 50) ? 4 : 5;
      chk("veh_b", c, ph, 1'b0, 1'b0, 1'b0);
      veh_b = (c >= 3);
      @(negedge clk);
    end
    $display("[TB] scenario veh_b done");

    // Pedestrian B request at cycle 2, no vehicle: walk_b then MIN_GREEN
    do_reset();
    for (int c = 0; c <= 33; c++) begin
      ph = (c < 10) ? 0 : (c < 14) ? 1 : (c < 16) ? 2 : (c < 26) ? 3 : (c < 30) ? 4 : (c < 32) ? 5 : 0;
      chk("ped_b", c, ph, 1'b0, (c >= 16 && c <= 23), 1'b0);
      ped_req_b = (c == 2);
      @(negedge clk);
    end
    $display("[TB] scenario ped_b done");

    // Preempt to A while B green at timer 2
    do_reset();
    for (int c = 0; c <= 52; c++) begin
      ph = (c < 10) ? 0 : (c < 14) ? 1 : (c < 16) ? 2 : (c < 19) ? 3 : (c < 23) ? 4 : (c < 25) ? 5 : (c < 51) ? 0 : 1;
      chk("emg_to_a", c, ph, 1'b0, 1'b0, (c >= 25 && c <= 40));
      veh_b   = 1'b1;
      emg_req = (c >= 18 && c < 40);
      emg_dir = 1'b0;
      @(negedge clk);
    end
    $display("[TB] scenario emg_to_a done");

    // Preempt to B from A rest, hold, then MIN_GREEN after release
    do_reset();
    for (int c = 0; c <= 54; c++) begin
      ph = (c < 21) ? 0 : (c < 25) ? 1 : (c < 27) ? 2 : (c < 51) ? 3 : 4;
      chk("emg_to_b", c, ph, 1'b0, 1'b0, (c >= 27 && c <= 40));
      emg_req = (c >= 20 && c < 40);
      emg_dir = 1'b1;
      @(negedge clk);
    end
    $display("[TB] scenario emg_to_b done");

    // Pedestrian A request during A green: B cut short, walk_a on next A green
    do_reset();
    for (int c = 0; c <= 43; c++) begin
      ph = (c < 10) ? 0 : (c < 14) ? 1 : (c < 16) ? 2 : (c < 26) ? 3 : (c < 30) ? 4 : (c < 32) ? 5 : (c < 42) ? 0 : 1;
      chk("ped_a", c, ph, (c >= 32 && c <= 39), 1'b0, 1'b0);
      veh_b     = 1'b1;
      ped_req_a = (c == 5);
      @(negedge clk);
    end
    $display("[TB] scenario ped_a done");

    // Async reset during B yellow, then pending A request must be gone
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      ph = (c < 10) ? 0 : (c < 14) ? 1 : (c < 16) ? 2 : (c < 26) ? 3 : 4;
      chk("pre_reset", c, ph, 1'b0, 1'b0, 1'b0);
      veh_b     = 1'b1;
      ped_req_a = (c == 5);
      if (c < 27) @(negedge clk);
    end
    #2 reset = 1'b1;
    #1 chk("async_reset", 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ped_req_a = 1'b0;
    veh_b     = 1'b1;
    reset     = 1'b0;
    for (int c = 0; c <= 27; c++) begin
      ph = (c < 10) ? 0 : (c < 14) ? 1 : (c < 16) ? 2 : 3;
      chk("post_reset", c, ph, 1'b0, 1'b0, 1'b0);
      veh_b = 1'b1;
      @(negedge clk);
    end
    $display("[TB] scenario reset_mid_phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
